// File: rtl/clk_div_sched.sv
// Runtime-programmable integer clock divider with boundary-aligned ratio switching and clean start/stop.
// Define CLK_DIV_ODD50_EN to add the negedge phase register that gives odd ratios 50% duty.
module clk_div_sched #(
   parameter int CNT_W   = 4,
   parameter int DIV_RST = 9
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic             cfg_vld,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_rdy,
   output logic             clk_div,
   output logic [CNT_W-1:0] div_cur,
   output logic             busy,
   output logic             err
);

   typedef enum logic [1:0] {IDLE, RUN, SW_PEND, STOP_PEND} state_t;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DIV_RST);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_div_cur;
   logic [CNT_W-1:0] w_div_cur_nxt;
   logic [CNT_W-1:0] r_div_nxt;
   logic [CNT_W-1:0] w_div_nxt_nxt;
   logic             r_stop;
   logic             w_stop_nxt;
   logic             r_p;
   logic             w_p_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_acc;
   logic             w_ok;
   logic             w_last;
   logic             w_half_end;
   logic [CNT_W-1:0] w_half;

   assign cfg_rdy    = (r_state == IDLE) || (r_state == RUN);
   assign busy       = (r_state == SW_PEND) || (r_state == STOP_PEND);
   assign div_cur    = r_div_cur;
   assign err        = r_err;
   assign w_acc      = cfg_vld & cfg_rdy;
   assign w_ok       = (cfg_div >= TWO);
   assign w_half     = r_div_cur >> 1;
   assign w_last     = (r_cnt == (r_div_cur - ONE));
   assign w_half_end = (r_cnt == (w_half - ONE));

   // Defaults describe a free-running period; each state only overrides what it must.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = w_last ? '0 : r_cnt + ONE;
      w_p_nxt       = w_last ? 1'b1 : (w_half_end ? 1'b0 : r_p);
      w_div_cur_nxt = r_div_cur;
      w_div_nxt_nxt = r_div_nxt;
      w_stop_nxt    = r_stop;
      w_err_nxt     = r_err | (w_acc & ~w_ok);
      case (r_state)
         IDLE: begin
            w_cnt_nxt  = '0;
            w_p_nxt    = en;
            w_stop_nxt = 1'b0;
            if (w_acc && w_ok) w_div_cur_nxt = cfg_div;
            if (en) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_acc && w_ok) begin
               w_div_nxt_nxt = cfg_div;
               w_stop_nxt    = ~en;
               w_state_nxt   = SW_PEND;
            end else if (!en) begin
               w_state_nxt = STOP_PEND;
            end
         end
         SW_PEND: begin
            if (w_last) begin
               w_div_cur_nxt = r_div_nxt;
               w_stop_nxt    = 1'b0;
               if (r_stop || !en) begin
                  w_p_nxt     = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = RUN;
               end
            end
         end
         STOP_PEND: begin
            if (en) begin
               w_state_nxt = RUN;
            end else if (w_last) begin
               w_p_nxt     = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_p       <= 1'b0;
         r_div_cur <= RST_DIV;
         r_div_nxt <= RST_DIV;
         r_stop    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_p       <= w_p_nxt;
         r_div_cur <= w_div_cur_nxt;
         r_div_nxt <= w_div_nxt_nxt;
         r_stop    <= w_stop_nxt;
         r_err     <= w_err_nxt;
      end
   end

`ifdef CLK_DIV_ODD50_EN
   logic r_n;

   // Half-cycle-delayed phase extends odd-ratio high time by half a source cycle.
   always_ff @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         r_n <= 1'b0;
      end else if (r_state == IDLE || !r_div_cur[0]) begin
         r_n <= 1'b0;
      end else if (r_cnt == '0) begin
         r_n <= 1'b1;
      end else if (r_cnt == w_half) begin
         r_n <= 1'b0;
      end
   end

   assign clk_div = r_p | r_n;
`else
   assign clk_div = r_p;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: expected pulse high times and periods are queued as runs start
// and checked by a half-cycle monitor on clk_div; control outputs are checked inline per scenario.
module tb_clk_div_sched;

   typedef struct {
      int high;
      int period;
   } exp_t;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       cfg_vld;
   logic [3:0] cfg_div;
   logic       cfg_rdy;
   logic       clk_div;
   logic [3:0] div_cur;
   logic       busy;
   logic       err;

   int   nTests = 0;
   int   nFail  = 0;
   exp_t sbQ[$];
   int   hc = 0;
   int   lastRise = 0;
   int   pendPeriod = 0;
   logic prevDiv = 1'b0;

   clk_div_sched #(.CNT_W(4), .DIV_RST(9)) dut (
      .clk(clk), .rstn(rstn), .en(en), .cfg_vld(cfg_vld), .cfg_div(cfg_div),
      .cfg_rdy(cfg_rdy), .clk_div(clk_div), .div_cur(div_cur), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   // Samples clk_div every half cycle; high time is measured in half cycles from rise to fall.
   always begin
      @(posedge clk or negedge clk);
      #1;
      hc++;
      if (clk_div === 1'b1 && prevDiv === 1'b0) begin
         if (pendPeriod > 0) begin
            nTests++;
            if (hc - lastRise !== 2 * pendPeriod) begin
               nFail++;
               $display("[TB] FAIL period: got %0d half-cycles, expected %0d", hc - lastRise, 2 * pendPeriod);
            end
         end
         pendPeriod = 0;
         lastRise   = hc;
      end
      if (clk_div === 1'b0 && prevDiv === 1'b1) begin
         nTests++;
         if (sbQ.size() == 0) begin
            nFail++;
            $display("[TB] FAIL pulse: got unexpected pulse of %0d half-cycles, expected none", hc - lastRise);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            if (e.high >= 0 && hc - lastRise !== e.high) begin
               nFail++;
               $display("[TB] FAIL high_time: got %0d half-cycles, expected %0d", hc - lastRise, e.high);
            end
            pendPeriod = e.period;
         end
      end
      prevDiv = clk_div;
   end

   function automatic int expHigh(input int n);
`ifdef CLK_DIV_ODD50_EN
      return n;
`else
      return 2 * (n / 2);
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic tickN(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic waitIdle(input int maxc, input string name);
      int i = 0;
      while (busy !== 1'b0 && i < maxc) begin
         tick();
         i++;
      end
      nTests++;
      if (busy !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL %s: busy=%b after %0d cycles, expected 0", name, busy, maxc);
      end
   endtask

   // Starts a run at the current ratio and drops en so that exactly nPulses periods are produced.
   task automatic runSeq(input int n, input int nPulses, input int off, input string name);
      exp_t e;
      en = 1'b1;
      for (int i = 0; i < nPulses; i++) begin
         e.high   = expHigh(n);
         e.period = (i < nPulses - 1) ? n : 0;
         sbQ.push_back(e);
      end
      tick();
      nTests++;
      if (div_cur !== 4'(n) || busy !== 1'b0 || cfg_rdy !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL %s_start: got div_cur=%0d busy=%b cfg_rdy=%b, expected %0d 0 1", name, div_cur, busy, cfg_rdy, n);
      end
      tickN(n * (nPulses - 1) + off - 1);
      en = 1'b0;
      tick();
      nTests++;
      if (busy !== 1'b1 || cfg_rdy !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL %s_stop_pend: got busy=%b cfg_rdy=%b, expected 1 0", name, busy, cfg_rdy);
      end
      waitIdle(2 * n + 4, name);
      nTests++;
      if (clk_div !== 1'b0 || cfg_rdy !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL %s_idle: got clk_div=%b cfg_rdy=%b, expected 0 1", name, clk_div, cfg_rdy);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      en = 1'b0;
      cfg_vld = 1'b0;
      cfg_div = 4'd0;
      tickN(2);
      nTests++;
      if (clk_div !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || cfg_rdy !== 1'b1 || div_cur !== 4'd9) begin
         nFail++;
         $display("[TB] FAIL reset: got clk_div=%b busy=%b err=%b cfg_rdy=%b div_cur=%0d, expected 0 0 0 1 9", clk_div, busy, err, cfg_rdy, div_cur);
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
      nTests++;
      if (clk_div !== 1'b0 || busy !== 1'b0 || div_cur !== 4'd9) begin
         nFail++;
         $display("[TB] FAIL reset_release: got clk_div=%b busy=%b div_cur=%0d, expected 0 0 9", clk_div, busy, div_cur);
      end
   endtask

   task automatic test_run9();
      runSeq(9, 3, 4, "run9");
   endtask

   task automatic test_switch();
      exp_t e;
      en = 1'b1;
      e.high = expHigh(9);
      e.period = 9;
      sbQ.push_back(e);
      tick();
      tickN(2);
      nTests++;
      if (cfg_rdy !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL sw_rdy_before: got %b, expected 1", cfg_rdy);
      end
      cfg_vld = 1'b1;
      cfg_div = 4'd4;
      tick();
      cfg_vld = 1'b0;
      nTests++;
      if (cfg_rdy !== 1'b0 || busy !== 1'b1 || div_cur !== 4'd9) begin
         nFail++;
         $display("[TB] FAIL sw_pend: got cfg_rdy=%b busy=%b div_cur=%0d, expected 0 1 9", cfg_rdy, busy, div_cur);
      end
      e.high = expHigh(4);
      e.period = 4;
      sbQ.push_back(e);
      e.period = 0;
      sbQ.push_back(e);
      tickN(5);
      nTests++;
      if (div_cur !== 4'd9 || busy !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL sw_before_boundary: got div_cur=%0d busy=%b, expected 9 1", div_cur, busy);
      end
      tick();
      nTests++;
      if (div_cur !== 4'd4 || busy !== 1'b0 || cfg_rdy !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL sw_applied: got div_cur=%0d busy=%b cfg_rdy=%b, expected 4 0 1", div_cur, busy, cfg_rdy);
      end
      tickN(4);
      en = 1'b0;
      tick();
      waitIdle(12, "sw_stop");
      nTests++;
      if (clk_div !== 1'b0 || div_cur !== 4'd4) begin
         nFail++;
         $display("[TB] FAIL sw_idle: got clk_div=%b div_cur=%0d, expected 0 4", clk_div, div_cur);
      end
   endtask

   task automatic test_stop5();
      cfg_vld = 1'b1;
      cfg_div = 4'd5;
      tick();
      cfg_vld = 1'b0;
      nTests++;
      if (div_cur !== 4'd5 || busy !== 1'b0 || clk_div !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL idle_load: got div_cur=%0d busy=%b clk_div=%b, expected 5 0 0", div_cur, busy, clk_div);
      end
      runSeq(5, 2, 3, "stop5");
   endtask

   task automatic test_err();
      exp_t e;
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e.high = expHigh(5);
         e.period = (i < 2) ? 5 : 0;
         sbQ.push_back(e);
      end
      tick();
      cfg_vld = 1'b1;
      cfg_div = 4'd1;
      tick();
      nTests++;
      if (err !== 1'b1 || busy !== 1'b0 || cfg_rdy !== 1'b1 || div_cur !== 4'd5) begin
         nFail++;
         $display("[TB] FAIL err_div1: got err=%b busy=%b cfg_rdy=%b div_cur=%0d, expected 1 0 1 5", err, busy, cfg_rdy, div_cur);
      end
      cfg_div = 4'd0;
      tick();
      cfg_vld = 1'b0;
      nTests++;
      if (err !== 1'b1 || busy !== 1'b0 || div_cur !== 4'd5) begin
         nFail++;
         $display("[TB] FAIL err_div0: got err=%b busy=%b div_cur=%0d, expected 1 0 5", err, busy, div_cur);
      end
      tickN(8);
      en = 1'b0;
      tick();
      waitIdle(14, "err_stop");
      nTests++;
      if (err !== 1'b1 || div_cur !== 4'd5) begin
         nFail++;
         $display("[TB] FAIL err_sticky: got err=%b div_cur=%0d, expected 1 5", err, div_cur);
      end
   endtask

   task automatic test_sw_stop();
      exp_t e;
      cfg_vld = 1'b1;
      cfg_div = 4'd6;
      tick();
      cfg_vld = 1'b0;
      en = 1'b1;
      e.high = expHigh(6);
      e.period = 0;
      sbQ.push_back(e);
      tick();
      tick();
      cfg_vld = 1'b1;
      cfg_div = 4'd3;
      en = 1'b0;
      tick();
      cfg_vld = 1'b0;
      nTests++;
      if (busy !== 1'b1 || cfg_rdy !== 1'b0 || div_cur !== 4'd6) begin
         nFail++;
         $display("[TB] FAIL swstop_pend: got busy=%b cfg_rdy=%b div_cur=%0d, expected 1 0 6", busy, cfg_rdy, div_cur);
      end
      tickN(3);
      nTests++;
      if (busy !== 1'b1 || div_cur !== 4'd6) begin
         nFail++;
         $display("[TB] FAIL swstop_hold: got busy=%b div_cur=%0d, expected 1 6", busy, div_cur);
      end
      tick();
      nTests++;
      if (busy !== 1'b0 || div_cur !== 4'd3 || clk_div !== 1'b0 || cfg_rdy !== 1'b1) begin
         nFail++;
         $display("[TB] FAIL swstop_idle: got busy=%b div_cur=%0d clk_div=%b cfg_rdy=%b, expected 0 3 0 1", busy, div_cur, clk_div, cfg_rdy);
      end
      tickN(3);
      nTests++;
      if (clk_div !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL swstop_quiet: got clk_div=%b, expected 0", clk_div);
      end
      runSeq(3, 2, 1, "swstop_run3");
   endtask

   task automatic test_reset_mid_switch();
      exp_t e;
      en = 1'b1;
      e.high = -1;
      e.period = 0;
      sbQ.push_back(e);
      tick();
      cfg_vld = 1'b1;
      cfg_div = 4'd7;
      tick();
      cfg_vld = 1'b0;
      en = 1'b0;
      nTests++;
      if (busy !== 1'b1 || cfg_rdy !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL rst_sw_pend: got busy=%b cfg_rdy=%b, expected 1 0", busy, cfg_rdy);
      end
      #1;
      rstn = 1'b0;
      #1;
      nTests++;
      if (clk_div !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || cfg_rdy !== 1'b1 || div_cur !== 4'd9) begin
         nFail++;
         $display("[TB] FAIL rst_mid: got clk_div=%b busy=%b err=%b cfg_rdy=%b div_cur=%0d, expected 0 0 0 1 9", clk_div, busy, err, cfg_rdy, div_cur);
      end
      @(negedge clk);
      rstn = 1'b1;
      tickN(2);
      nTests++;
      if (div_cur !== 4'd9 || busy !== 1'b0 || clk_div !== 1'b0) begin
         nFail++;
         $display("[TB] FAIL rst_mid_release: got div_cur=%0d busy=%b clk_div=%b, expected 9 0 0", div_cur, busy, clk_div);
      end
      runSeq(9, 2, 1, "rst_mid_run9");
   endtask

   initial begin
      test_reset();
      test_run9();
      test_switch();
      test_stop5();
      test_err();
      test_sw_stop();
      test_reset_mid_switch();
      tickN(4);
      nTests++;
      if (sbQ.size() != 0) begin
         nFail++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending pulses, expected 0", sbQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
